// File: rtl/grad_magnitude_threshold_if.sv
// Stream interface between the Sobel gradient source and grad_magnitude_threshold.
// The dirOut signal exists only when GRAD_DIR_EN is defined.
interface grad_magnitude_threshold_if;
  logic [15:0] gradIn;
  logic        gradValid;
  logic [7:0]  magOut;
  logic [7:0]  edgeOut;
  logic        outValid;
  logic        outLast;
  logic        frameDone;
`ifdef GRAD_DIR_EN
  logic [1:0]  dirOut;

  modport master (output gradIn, gradValid,
                  input  magOut, edgeOut, outValid, outLast, frameDone, dirOut);
  modport slave  (input  gradIn, gradValid,
                  output magOut, edgeOut, outValid, outLast, frameDone, dirOut);
`else
  modport master (output gradIn, gradValid,
                  input  magOut, edgeOut, outValid, outLast, frameDone);
  modport slave  (input  gradIn, gradValid,
                  output magOut, edgeOut, outValid, outLast, frameDone);
`endif
endinterface

// File: rtl/grad_magnitude_threshold.sv
// Buffers a Gx plane, then emits saturated |Gx|+|Gy| magnitude and edge flag per Gy sample.
// Optional quantised direction output is built when GRAD_DIR_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for Gx[0] of a new frame
// S_LOADX | storing Gx[1..N-1] into the plane buffer
// S_LOADY | streaming Gy, one registered output per sample
// S_DONE  | one-cycle frame gap; frameDone follows it
module grad_magnitude_threshold #(
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int THRESH = 100
) (
  input logic                     clk,
  input logic                     reset,
  grad_magnitude_threshold_if.slave gif
);
  localparam int N     = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [7:0]       THRESH_8 = 8'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_LOADX, S_LOADY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [12:0]      gx_mem [N];

  logic [7:0] mag_q, mag_d;
  logic [7:0] edge_q, edge_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       done_q, done_d;

  logic        idx_last, gx_wr, gy_take;
  logic [12:0] gx_cur, gy_cur, ax, ay;
  logic [13:0] sum;
  logic [7:0]  mag_new;
  logic        unused_hi;

  function automatic logic [12:0] abs13(input logic [12:0] v);
    return v[12] ? (~v + 13'd1) : v;
  endfunction

  assign unused_hi = ^gif.gradIn[15:13];
  assign idx_last  = (idx_q == LAST_IDX);
  assign gx_wr     = gif.gradValid && (state_q == S_IDLE || state_q == S_LOADX);
  assign gy_take   = gif.gradValid && (state_q == S_LOADY);

  // Plane buffer is deliberately not reset; each frame rewrites every entry.
  always_ff @(posedge clk) begin
    if (gx_wr) gx_mem[idx_q] <= gif.gradIn[12:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (gif.gradValid) begin
          idx_d   = ONE_IDX;
          state_d = S_LOADX;
        end
      end
      S_LOADX, S_LOADY: begin
        if (gif.gradValid) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = (state_q == S_LOADX) ? S_LOADY : S_DONE;
          end else begin
            idx_d = idx_q + ONE_IDX;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    gx_cur  = gx_mem[idx_q];
    gy_cur  = gif.gradIn[12:0];
    ax      = abs13(gx_cur);
    ay      = abs13(gy_cur);
    sum     = {1'b0, ax} + {1'b0, ay};
    mag_new = (sum > 14'd255) ? 8'hFF : sum[7:0];
    valid_d = gy_take;
    last_d  = gy_take && idx_last;
    done_d  = (state_q == S_DONE);
    mag_d   = gy_take ? mag_new : mag_q;
    edge_d  = gy_take ? ((mag_new >= THRESH_8) ? 8'hFF : 8'h00) : edge_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_q   <= '0;
      edge_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      edge_q  <= edge_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign gif.magOut    = mag_q;
  assign gif.edgeOut   = edge_q;
  assign gif.outValid  = valid_q;
  assign gif.outLast   = last_q;
  assign gif.frameDone = done_q;

`ifdef GRAD_DIR_EN
  logic [1:0]  dir_q, dir_d;
  logic [15:0] five_ax, five_ay, two_ax, two_ay;
  logic [1:0]  dir_new;

  // Zero counts as positive, so the sign bit alone decides the diagonal.
  always_comb begin
    five_ax = {3'b000, ax} * 16'd5;
    five_ay = {3'b000, ay} * 16'd5;
    two_ax  = {2'b00, ax, 1'b0};
    two_ay  = {2'b00, ay, 1'b0};
    if (five_ay <= two_ax)      dir_new = 2'd0;
    else if (five_ax <= two_ay) dir_new = 2'd2;
    else                        dir_new = (gx_cur[12] == gy_cur[12]) ? 2'd1 : 2'd3;
    dir_d = gy_take ? dir_new : dir_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dir_q <= '0;
    else        dir_q <= dir_d;
  end

  assign gif.dirOut = dir_q;
`endif

endmodule

// File: tb/tb_grad_magnitude_threshold.sv
// Scoreboard bench for grad_magnitude_threshold: driver pushes expected pixels, a monitor pops on outValid.
// Exercises direction outputs too when GRAD_DIR_EN is defined.
module tb_grad_magnitude_threshold;
  localparam int N = 26 * 26;

  logic clk;
  logic reset;
  grad_magnitude_threshold_if gif ();

  grad_magnitude_threshold #(.IMG_W(26), .IMG_H(26), .THRESH(100)) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mag;
    int edg;
    int last;
    int dir;
  } exp_t;

  exp_t        q[$];
  logic [15:0] gx_arr [N];
  logic [15:0] gy_arr [N];
  int total = 0;
  int bad = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx13(input logic [15:0] g);
    int v;
    v = int'(g[12:0]);
    if (g[12]) v = v - 8192;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model(input int k);
    exp_t e;
    int gx, gy, ax, ay, s;
    gx = sx13(gx_arr[k]);
    gy = sx13(gy_arr[k]);
    ax = iabs(gx);
    ay = iabs(gy);
    s = ax + ay;
    e.mag  = (s > 255) ? 255 : s;
    e.edg  = (e.mag >= 100) ? 255 : 0;
    e.last = (k == N - 1) ? 1 : 0;
    if (5 * ay <= 2 * ax)      e.dir = 0;
    else if (5 * ax <= 2 * ay) e.dir = 2;
    else                       e.dir = ((gx < 0) == (gy < 0)) ? 1 : 3;
    return e;
  endfunction

  // Inputs change 1 time unit after the rising edge; each call consumes one clock.
  task automatic send(input logic [15:0] g, input logic v);
    gif.gradIn    = g;
    gif.gradValid = v;
    @(posedge clk);
    #1;
    gif.gradValid = 1'b0;
  endtask

  task automatic send_frame(input int duty, input int n_gy);
    for (int k = 0; k < N; k++) begin
      while (int'($urandom_range(99)) >= duty) send(16'($urandom), 1'b0);
      send(gx_arr[k], 1'b1);
    end
    for (int k = 0; k < n_gy; k++) begin
      while (int'($urandom_range(99)) >= duty) send(16'($urandom), 1'b0);
      q.push_back(model(k));
      send(gy_arr[k], 1'b1);
    end
  endtask

  task automatic settle_and_check(input string name, input int outs0, input int done0,
                                  input int n_frames);
    int budget;
    budget = 0;
    while (q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_drain"}, q.size(), 0);
    chk({name, "_outcount"}, out_cnt - outs0, n_frames * N);
    chk({name, "_donecount"}, done_cnt - done0, n_frames);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_grad();
    logic [15:0] g;
    if ($urandom_range(1) == 1) g = 16'(int'($urandom_range(600)) - 300);
    else                        g = 16'($urandom);
    g[15:13] = 3'($urandom);
    return g;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_last = 1'b0;
    end else begin
      if (gif.frameDone || prev_last) chk("frame_done_timing", int'(gif.frameDone), int'(prev_last));
      if (gif.frameDone) done_cnt++;
      if (gif.outValid) begin
        out_cnt++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got outValid=1 expected no output, mag=%0d at %0t",
                   gif.magOut, $time);
        end else begin
          e = q.pop_front();
          chk("mag", int'(gif.magOut), e.mag);
          chk("edge", int'(gif.edgeOut), e.edg);
          chk("last", int'(gif.outLast), e.last);
`ifdef GRAD_DIR_EN
          chk("dir", int'(gif.dirOut), e.dir);
`endif
        end
      end
      prev_last = gif.outValid && gif.outLast;
    end
  end

  initial begin
    int o0, d0;
    reset         = 1'b0;
    gif.gradIn    = '0;
    gif.gradValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mag", int'(gif.magOut), 0);
    chk("rst_edge", int'(gif.edgeOut), 0);
    chk("rst_valid", int'(gif.outValid), 0);
    chk("rst_last", int'(gif.outLast), 0);
    chk("rst_done", int'(gif.frameDone), 0);
`ifdef GRAD_DIR_EN
    chk("rst_dir", int'(gif.dirOut), 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, contiguous
    for (int k = 0; k < N; k++) begin
      gx_arr[k] = 16'(k - 338);
      gy_arr[k] = 16'h0000;
    end
    o0 = out_cnt; d0 = done_cnt;
    send_frame(100, N);
    settle_and_check("ramp", o0, d0, 1);

    // Same ramp with ~30% valid duty
    o0 = out_cnt; d0 = done_cnt;
    send_frame(30, N);
    settle_and_check("gappy", o0, d0, 1);

    // Extremes and direction cases, then a random frame after a single-cycle gap
    for (int k = 0; k < N; k++) begin
      gx_arr[k] = rnd_grad();
      gy_arr[k] = rnd_grad();
    end
    gx_arr[0] = 16'hF000; gy_arr[0] = 16'h0FFF;
    gx_arr[1] = 16'd50;   gy_arr[1] = 16'd50;
    gx_arr[2] = 16'd49;   gy_arr[2] = 16'd49;
    gx_arr[3] = 16'd100;  gy_arr[3] = 16'd10;
    gx_arr[4] = 16'd10;   gy_arr[4] = 16'd100;
    gx_arr[5] = 16'd50;   gy_arr[5] = 16'hFFCE;
    gx_arr[6] = 16'd0;    gy_arr[6] = 16'd0;
    gx_arr[7] = 16'hE000; gy_arr[7] = 16'h1000;
    o0 = out_cnt; d0 = done_cnt;
    send_frame(100, N);
    send(16'h0000, 1'b0);
    for (int k = 0; k < N; k++) begin
      gx_arr[k] = rnd_grad();
      gy_arr[k] = rnd_grad();
    end
    send_frame(100, N);
    settle_and_check("b2b", o0, d0, 2);

    // Reset in the middle of the Gy plane, at pixel 300
    for (int k = 0; k < N; k++) begin
      gx_arr[k] = rnd_grad();
      gy_arr[k] = rnd_grad();
    end
    send_frame(100, 300);
    @(negedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("midrst_mag", int'(gif.magOut), 0);
      chk("midrst_edge", int'(gif.edgeOut), 0);
      chk("midrst_valid", int'(gif.outValid), 0);
      chk("midrst_last", int'(gif.outLast), 0);
      chk("midrst_done", int'(gif.frameDone), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      gx_arr[k] = 16'd10;
      gy_arr[k] = 16'hFFF6;
    end
    o0 = out_cnt; d0 = done_cnt;
    send_frame(100, N);
    settle_and_check("post_rst", o0, d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
